// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, status codes, and
// the word-offset helper.
package dmem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef enum logic [2:0] {
    SAOK = 3'h1,
    SHLT = 3'h2,
    SADR = 3'h3,
    SINS = 3'h4
  } stat_e;

  // Number of byte-offset bits inside one data word.
  function automatic int unsigned word_offs_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with synchronous write and registered synchronous read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 512,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Clocked data memory with valid/ready request channel, LATENCY-cycle commit and a held
// response. Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_error,
  output logic              o_busy
);

  localparam int unsigned OFFS_W = word_offs_w(DATA_W);
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // One extra bit so the limit never wraps when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0]  MEM_BYTES = (ADDR_W + 1)'(DEPTH * BYTES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

  logic [1:0]        r_state;
  logic              r_req_ready;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic              r_err;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic              r_rd_ok;

  logic [IDX_W-1:0]  w_idx;
  logic              w_range_err;
  logic              w_misalign;
  logic              w_err;
  logic              w_commit;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_idx       = IDX_W'(i_req_addr >> OFFS_W);
  assign w_range_err = ({1'b0, i_req_addr} >= MEM_BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign  = ((i_req_addr & ADDR_W'(BYTES - 1)) != '0);
`else
  assign w_misalign  = 1'b0;
`endif
  assign w_err       = w_range_err | w_misalign;
  assign w_commit    = (r_state == WAIT) && (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rd_ok      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_req_ready && i_req_valid) begin
            r_write     <= i_req_write;
            r_idx       <= w_idx;
            r_wdata     <= i_req_wdata;
            r_err       <= w_err;
            r_cnt       <= CNT_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (w_commit) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_err;
            r_rd_ok      <= ~r_write & ~r_err;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk  (i_clk),
    .i_we   (w_commit & r_write & ~r_err),
    .i_re   (w_commit & ~r_write & ~r_err),
    .i_idx  (r_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_arr_rdata)
  );

  // The array read register holds until the next read commit, so gating it is enough.
  assign o_resp_rdata = r_rd_ok ? w_arr_rdata : '0;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_error = r_resp_err;
  assign o_req_ready  = r_req_ready;
  assign o_busy       = (r_state != IDLE);

endmodule
